// File: rtl/demux1_3_stream.sv
// demux1_3_stream: registered 1-to-3 valid/ready demux, round-robin or explicit steering
module demux1_3_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             rr_mode,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    output logic             err_sel
);
    logic [1:0]       rr_ptr, t;
    logic [2:0]       valid_q, rdy, hit, free, load;
    logic [WIDTH-1:0] data_q [3];
    always_comb begin
        t        = rr_mode ? rr_ptr : sel;
        rdy      = {out_ready2, out_ready1, out_ready0};
        hit      = {t == 2'd2, t == 2'd1, t == 2'd0};
        free     = ~valid_q | rdy;
        in_ready = |(hit & free);
        load     = in_valid ? (hit & free) : 3'b000;
    end
    // a load into a draining slot wins over the drain
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rr_ptr  <= '0;
            err_sel <= 1'b0;
            for (int k = 0; k < 3; k++) data_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= in_data;
                end else if (rdy[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (rr_mode && |load) rr_ptr <= (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
            if (!rr_mode && sel == 2'd3 && in_valid) err_sel <= 1'b1;
        end
    end
    assign {out_valid2, out_valid1, out_valid0} = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
endmodule
